// File: rtl/conv_window_buffer.sv
// conv_window_buffer
// Multi-channel sliding-window generator for the CNN datapath. Pixels arrive
// in raster order. KERNEL_ROW_SIZE-1 line buffers and a KERNEL_COLUMN_SIZE-deep
// shift register build each window. Geometry and stride are latched on the
// first pixel of every frame. Valid/ready handshakes are used on both sides.
module conv_window_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int CHANNELS           = 1,
    parameter int BUFFER_LENGTH      = 2000,
    parameter int MAX_ROWS           = 2048,
    parameter int KERNEL_ROW_SIZE    = 3,
    parameter int KERNEL_COLUMN_SIZE = 3
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DATA_WIDTH*CHANNELS-1:0]         in_point,
    input  logic                                   valid_in,
    output logic                                   ready_in,
    input  logic [$clog2(BUFFER_LENGTH)-1:0]       frame_column_size,
    input  logic [$clog2(MAX_ROWS)-1:0]            frame_row_size,
    input  logic [1:0]                             stride,
    output logic [DATA_WIDTH*CHANNELS*KERNEL_ROW_SIZE*KERNEL_COLUMN_SIZE-1:0] out_matrix,
    output logic                                   valid_out,
    input  logic                                   ready_out,
    output logic                                   frame_done,
    output logic                                   cfg_error
);

    localparam int KR  = KERNEL_ROW_SIZE;
    localparam int KC  = KERNEL_COLUMN_SIZE;
    localparam int PW  = DATA_WIDTH * CHANNELS;
    localparam int OW  = PW * KR * KC;
    localparam int CW  = $clog2(BUFFER_LENGTH);
    localparam int RW  = $clog2(MAX_ROWS);
    localparam int LBR = (KR > 1) ? KR - 1 : 1;

    localparam logic [CW-1:0] KC_M1 = CW'(KC - 1);
    localparam logic [RW-1:0] KR_M1 = RW'(KR - 1);

    // frame position and per-frame latched geometry
    logic [CW-1:0] col_q, col_d, last_col_q, last_col_e, last_col_in;
    logic [RW-1:0] row_q, row_d, last_row_q, last_row_e, last_row_in;
    logic [1:0]    stride_q, stride_e, stride_in;
    logic [1:0]    col_ph_q, col_ph_d, row_ph_q, row_ph_d;
    logic          bad_q, bad_e, bad_in;
    int            cols_in_i, rows_in_i;

    // output side
    logic          valid_q, done_q, err_q;
    logic [OW-1:0] out_q, out_d;

    logic          accept, first_px, col_wrap, row_wrap, emit;

    // line buffers: index 0 holds the oldest row
    logic [PW-1:0] lb_q    [LBR][BUFFER_LENGTH];
    // window shift register: [row][column], column 0 is the leftmost
    logic [PW-1:0] win_q   [KR][KC];
    logic [PW-1:0] win_d   [KR][KC];
    logic [PW-1:0] col_vec [KR];

    assign accept   = valid_in && ready_in;
    assign ready_in = !valid_q || ready_out;
    assign first_px = (col_q == '0) && (row_q == '0);

    assign cols_in_i = int'(frame_column_size);
    assign rows_in_i = int'(frame_row_size);

    // Evaluate incoming geometry. It only matters on the first pixel of a frame.
    always_comb begin
        bad_in      = (cols_in_i < KC) || (cols_in_i > BUFFER_LENGTH) ||
                      (rows_in_i < KR) || (rows_in_i > MAX_ROWS);
        last_col_in = (frame_column_size == '0) ? '0 : frame_column_size - 1'b1;
        last_row_in = (frame_row_size == '0) ? '0 : frame_row_size - 1'b1;
        stride_in   = (stride == 2'd0) ? 2'd1 : stride;
        // The first pixel uses the live inputs, because they are latched on that same edge.
        last_col_e  = first_px ? last_col_in : last_col_q;
        last_row_e  = first_px ? last_row_in : last_row_q;
        stride_e    = first_px ? stride_in   : stride_q;
        bad_e       = first_px ? bad_in      : bad_q;
    end

    // Next raster position and stride phases. A phase restarts at 0 when its axis
    // reaches the first full-window coordinate.
    always_comb begin
        col_wrap = (col_q == last_col_e);
        row_wrap = (row_q == last_row_e);
        col_d    = col_q;
        row_d    = row_q;
        col_ph_d = col_ph_q;
        row_ph_d = row_ph_q;
        if (col_wrap) begin
            col_d    = '0;
            col_ph_d = '0;
            if (row_wrap) begin
                row_d    = '0;
                row_ph_d = '0;
            end else begin
                row_d = row_q + 1'b1;
                if (int'(row_q) + 1 <= KR - 1) begin
                    row_ph_d = '0;
                end else if (row_ph_q == stride_e - 2'd1) begin
                    row_ph_d = '0;
                end else begin
                    row_ph_d = row_ph_q + 2'd1;
                end
            end
        end else begin
            col_d = col_q + 1'b1;
            if (int'(col_q) + 1 <= KC - 1) begin
                col_ph_d = '0;
            end else if (col_ph_q == stride_e - 2'd1) begin
                col_ph_d = '0;
            end else begin
                col_ph_d = col_ph_q + 2'd1;
            end
        end
    end

    // A window is emitted only once the current row and column can complete it and both phases are 0.
    assign emit = accept && !bad_e && (row_q >= KR_M1) && (col_q >= KC_M1) &&
                  (row_ph_q == 2'd0) && (col_ph_q == 2'd0);

    // Build the new rightmost column from the line buffers plus the incoming pixel, then shift the window.
    always_comb begin
        for (int k = 0; k < KR - 1; k++) begin
            col_vec[k] = lb_q[k][col_q];
        end
        col_vec[KR-1] = in_point;
        for (int i = 0; i < KR; i++) begin
            for (int j = 0; j < KC - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][KC-1] = col_vec[i];
        end
        out_d = '0;
        for (int i = 0; i < KR; i++) begin
            for (int j = 0; j < KC; j++) begin
                out_d[PW*(i*KC+j) +: PW] = win_d[i][j];
            end
        end
    end

    // Line buffers and window storage. Stale data is never cleared; row gating keeps it out of any emitted window.
    always_ff @(posedge clk) begin
        if (accept && !bad_e) begin
            for (int k = 0; k < KR - 1; k++) begin
                lb_q[k][col_q] <= col_vec[k+1];
            end
            for (int i = 0; i < KR; i++) begin
                for (int j = 0; j < KC; j++) begin
                    win_q[i][j] <= win_d[i][j];
                end
            end
        end
    end

    // Counters, geometry latch, output register and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            col_ph_q   <= '0;
            row_ph_q   <= '0;
            last_col_q <= '0;
            last_row_q <= '0;
            stride_q   <= 2'd1;
            bad_q      <= 1'b0;
            valid_q    <= 1'b0;
            out_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                col_q    <= col_d;
                row_q    <= row_d;
                col_ph_q <= col_ph_d;
                row_ph_q <= row_ph_d;
                done_q   <= col_wrap && row_wrap;
                if (first_px) begin
                    last_col_q <= last_col_in;
                    last_row_q <= last_row_in;
                    stride_q   <= stride_in;
                    bad_q      <= bad_in;
                    if (bad_in) begin
                        err_q <= 1'b1;
                    end
                end
            end
            if (emit) begin
                valid_q <= 1'b1;
                out_q   <= out_d;
            end else if (ready_out) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_matrix = out_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;
    assign cfg_error  = err_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer: two-channel 6x6 frames with
// hand-computed first and last windows, plus reset and bad-geometry sequences.
module tb_conv_window_buffer;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int BL = 32;
    localparam int MR = 32;
    localparam int KR = 3;
    localparam int KC = 3;
    localparam int PW = DW * CH;
    localparam int OW = PW * KR * KC;
    localparam int CW = $clog2(BL);
    localparam int RW = $clog2(MR);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [PW-1:0] in_point;
    logic          valid_in, ready_in;
    logic [CW-1:0] frame_column_size;
    logic [RW-1:0] frame_row_size;
    logic [1:0]    stride;
    logic [OW-1:0] out_matrix;
    logic          valid_out, ready_out, frame_done, cfg_error;

    always #5 clk = ~clk;

    conv_window_buffer #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .BUFFER_LENGTH(BL), .MAX_ROWS(MR),
        .KERNEL_ROW_SIZE(KR), .KERNEL_COLUMN_SIZE(KC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_point(in_point), .valid_in(valid_in),
        .ready_in(ready_in), .frame_column_size(frame_column_size),
        .frame_row_size(frame_row_size), .stride(stride), .out_matrix(out_matrix),
        .valid_out(valid_out), .ready_out(ready_out), .frame_done(frame_done),
        .cfg_error(cfg_error)
    );

    typedef struct {
        int            strd;
        int            stall;
        int            gaps;
        int            midchg;
        int            exp_n;
        logic [OW-1:0] first_w;
        logic [OW-1:0] last_w;
    } vec_t;

    vec_t          vecs[7];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [OW-1:0] got[$];
    int            done_cnt;
    int            done_win;
    int            stall_seen;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // channel0 = value, channel1 = 255 - value, elements listed row by row
    function automatic logic [OW-1:0] pack_rows(input int a0, a1, a2, b0, b1, b2, c0, c1, c2);
        int v[9];
        logic [OW-1:0] r;
        v = '{a0, a1, a2, b0, b1, b2, c0, c1, c2};
        r = '0;
        for (int k = 0; k < 9; k++) begin
            r[PW*k +: DW]      = 8'(v[k]);
            r[PW*k + DW +: DW] = 8'(255 - v[k]);
        end
        return r;
    endfunction

    // Window whose top-left pixel sits at (r0,c0) in a frame numbered 1.. in raster order
    function automatic logic [OW-1:0] model_win(input int cols, input int r0, input int c0);
        logic [OW-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < KR; i++) begin
            for (int j = 0; j < KC; j++) begin
                v = (r0 + i) * cols + c0 + j + 1;
                r[PW*(i*KC+j) +: DW]      = 8'(v);
                r[PW*(i*KC+j) + DW +: DW] = 8'(255 - v);
            end
        end
        return r;
    endfunction

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n    = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_int({tag, "_valid_out"}, int'(valid_out), 0);
        check({tag, "_out_matrix"}, out_matrix, '0);
        check_int({tag, "_frame_done"}, int'(frame_done), 0);
        check_int({tag, "_cfg_error"}, int'(cfg_error), 0);
        check_int({tag, "_ready_in"}, int'(ready_in), 1);
        rst_n = 1'b1;
    endtask

    // Drive npix pixels of a cols x rows frame and collect every consumed window
    task automatic run_frame(input int cols, input int rows, input int strd, input int stall,
                             input int gaps, input int midchg, input int npix, output int accepted);
        int p;
        int cyc;
        int drain;
        logic [OW-1:0] held;
        p          = 1;
        cyc        = 0;
        drain      = 4;
        accepted   = 0;
        held       = '0;
        stall_seen = 0;
        done_cnt   = 0;
        done_win   = -1;
        got.delete();
        frame_column_size = CW'(cols);
        frame_row_size    = RW'(rows);
        stride            = 2'(strd);
        while ((p <= npix || drain > 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (midchg != 0 && accepted >= 1) begin
                frame_column_size = CW'(4);
                frame_row_size    = RW'(4);
                stride            = 2'd3;
            end
            if (p <= npix) begin
                valid_in = !(gaps != 0 && (cyc % 3 == 0));
                in_point = {8'(255 - p), 8'(p)};
            end else begin
                valid_in = 1'b0;
                drain--;
            end
            if (stall != 0 && valid_out && stall_seen < 5) begin
                ready_out = 1'b0;
                if (stall_seen == 0) held = out_matrix;
                else check("stall_hold", out_matrix, held);
                stall_seen++;
            end else begin
                ready_out = 1'b1;
            end
            #1;
            if (!ready_out) check_int("stall_ready_in", int'(ready_in), 0);
            if (valid_out && ready_out) got.push_back(out_matrix);
            if (frame_done) begin
                done_cnt++;
                done_win = int'(valid_out);
            end
            if (valid_in && ready_in) begin
                accepted++;
                p++;
            end
        end
        check_int("frame_in_budget", (cyc < 400) ? 1 : 0, 1);
    endtask

    task automatic check_seq(input string tag, input int cols, input int rows, input int s);
        int n;
        int eff;
        n   = 0;
        eff = (s == 0) ? 1 : s;
        for (int r0 = 0; r0 + KR <= rows; r0 += eff) begin
            for (int c0 = 0; c0 + KC <= cols; c0 += eff) begin
                if (n < got.size()) check($sformatf("%s_win%0d", tag, n), got[n], model_win(cols, r0, c0));
                n++;
            end
        end
        check_int({tag, "_count"}, got.size(), n);
    endtask

    initial begin
        logic [OW-1:0] f1, l1, l2, gf, gl;
        int acc;
        int eff;
        logic [7:0] ch1 [9];
        int exp_ch1 [9];

        rst_n = 1'b0;
        valid_in = 1'b0;
        ready_out = 1'b1;
        in_point = '0;
        frame_column_size = CW'(6);
        frame_row_size = RW'(6);
        stride = 2'd1;

        f1 = pack_rows(1, 2, 3, 7, 8, 9, 13, 14, 15);
        l1 = pack_rows(22, 23, 24, 28, 29, 30, 34, 35, 36);
        l2 = pack_rows(15, 16, 17, 21, 22, 23, 27, 28, 29);
        //           strd stall gaps midchg exp_n first last
        vecs[0] = '{1, 0, 0, 0, 16, f1, l1};
        vecs[1] = '{2, 0, 0, 0,  4, f1, l2};
        vecs[2] = '{1, 1, 0, 0, 16, f1, l1};
        vecs[3] = '{0, 0, 0, 0, 16, f1, l1};
        vecs[4] = '{3, 0, 0, 0,  4, f1, l1};
        vecs[5] = '{2, 0, 0, 1,  4, f1, l2};
        vecs[6] = '{1, 0, 1, 0, 16, f1, l1};

        do_reset("init");

        for (int v = 0; v < 7; v++) begin
            run_frame(6, 6, vecs[v].strd, vecs[v].stall, vecs[v].gaps, vecs[v].midchg, 36, acc);
            eff = (vecs[v].strd == 0) ? 1 : vecs[v].strd;
            gf = (got.size() > 0) ? got[0] : '0;
            gl = (got.size() > 0) ? got[got.size()-1] : '0;
            check_int($sformatf("v%0d_accepted", v), acc, 36);
            check_int($sformatf("v%0d_windows", v), got.size(), vecs[v].exp_n);
            check($sformatf("v%0d_first", v), gf, vecs[v].first_w);
            check($sformatf("v%0d_last", v), gl, vecs[v].last_w);
            check_int($sformatf("v%0d_frame_done", v), done_cnt, 1);
            check_int($sformatf("v%0d_done_with_win", v), done_win,
                      (((6 - KR) % eff == 0) && ((6 - KC) % eff == 0)) ? 1 : 0);
            check_int($sformatf("v%0d_cfg_error", v), int'(cfg_error), 0);
            if (vecs[v].stall != 0) check_int($sformatf("v%0d_stall_cycles", v), stall_seen, 5);
            check_seq($sformatf("v%0d", v), 6, 6, vecs[v].strd);
        end

        // channel 1 of the first stride-1 window, read out element by element
        run_frame(6, 6, 1, 0, 0, 0, 36, acc);
        gf = (got.size() > 0) ? got[0] : '0;
        exp_ch1 = '{254, 253, 252, 248, 247, 246, 242, 241, 240};
        for (int k = 0; k < 9; k++) begin
            ch1[k] = gf[DW*(1 + CH*k) +: DW];
            check_int($sformatf("ch1_elem%0d", k), int'(ch1[k]), exp_ch1[k]);
        end

        // reset after pixel 20, then a clean frame must reproduce the full sequence
        run_frame(6, 6, 1, 0, 0, 0, 20, acc);
        check_int("partial_accepted", acc, 20);
        check_int("partial_frame_done", done_cnt, 0);
        do_reset("midrst");
        run_frame(6, 6, 1, 0, 0, 0, 36, acc);
        check_int("post_rst_frame_done", done_cnt, 1);
        check_seq("post_rst", 6, 6, 1);

        // too few columns: pixels consumed, no windows, sticky error
        run_frame(2, 6, 1, 0, 0, 0, 12, acc);
        check_int("cfgcol_accepted", acc, 12);
        check_int("cfgcol_windows", got.size(), 0);
        check_int("cfgcol_frame_done", done_cnt, 1);
        check_int("cfgcol_cfg_error", int'(cfg_error), 1);
        run_frame(6, 6, 1, 0, 0, 0, 36, acc);
        check_int("cfg_sticky", int'(cfg_error), 1);
        do_reset("cfgrst");

        // too few rows
        run_frame(6, 2, 1, 0, 0, 0, 12, acc);
        check_int("cfgrow_accepted", acc, 12);
        check_int("cfgrow_windows", got.size(), 0);
        check_int("cfgrow_frame_done", done_cnt, 1);
        check_int("cfgrow_cfg_error", int'(cfg_error), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
